serial_add: RTL
===============

# serial_add

Multi-cycle, parametrised successor to the team's 1-bit full adder. Adds two WIDTH-bit operands plus carry-in by iterating a SLICE-bit ripple full-adder stage, one slice per clock, LSB slice first, under a start/busy/done handshake. Used in area-constrained datapaths where a full-width combinational adder is too large.

## Interface

- WIDTH, 8: operand and sum width in bits; WIDTH ≥ 1.
- SLICE, 1: bits added per cycle; WIDTH % SLICE == 0 is required, else elaboration error.
- NSL (localparam) = WIDTH/SLICE: slices per operation.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted on a rising edge when busy=0.
- a  in  WIDTH  operand A, sampled on accept.
- b  in  WIDTH  operand B, sampled on accept.
- cin  in  1  carry-in, sampled on accept.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when sum/cout/ovf update.
- sum  out  WIDTH  result, registered.
- cout  out  1  carry out of MSB.
- ovf  out  1  signed overflow: carry into MSB XOR cout.

## Operation

- FSM states: IDLE, RUN.
- IDLE: if start=1, latch a, b, cin, clear slice counter k to 0, go RUN. busy=1 from the next cycle.
- RUN: each cycle adds slice k of A, slice k of B and the running carry with a SLICE-bit ripple of full-adder cells (s = x^y^z, c = xy|xz|yz), writes slice k of an internal result register, stores the carry, increments k.
- On the cycle processing slice NSL-1: copy the internal result to sum, set cout and ovf, pulse done=1, set busy=0, return to IDLE.
- sum/cout/ovf change only on done; they hold the last result until the next completion. Partial results are never visible.
- start while busy=1 is ignored (not queued). a/b/cin changes during RUN have no effect.
- Back-to-back: start asserted in the done cycle is accepted (busy=0 then), so sustained throughput is one result per NSL+1 cycles.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1). ovf defined for two's-complement interpretation.
- WIDTH=1, SLICE=1 degenerates to one cycle in RUN.

## Timing

- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, k=0, internal registers 0. Reset mid-operation aborts it; no done is produced and outputs return to 0.
- Accept at edge E0: busy=1 after E0.
- Slice k is computed at edge E0+1+k; done=1 and new sum/cout/ovf visible after edge E0+NSL; busy=0 in the same cycle.
- Latency start-accept to done: NSL cycles. done is high for exactly one cycle.
- start and rst_n=0 together: reset wins.

## Configuration

- SERIAL_ADD_SUB_EN defined: adds input port sub (1 bit, sampled on accept). When sub=1, the B operand is taken as ~b and the effective carry-in is cin^1, so sub=1, cin=0 yields a − b; cout=1 means no borrow; ovf is signed subtraction overflow.
- Not defined: no sub port; block is add-only as above.

## Test plan

- Reset: hold rst_n=0 two cycles -> busy=0, done=0, sum=0, cout=0, ovf=0.
- WIDTH=8, SLICE=1: a=8'h5A, b=8'h3C, cin=1 -> done exactly 8 cycles after accept, sum=8'h97, cout=0, ovf=1.
- WIDTH=8, SLICE=4: a=8'hFF, b=8'h01, cin=0 -> done 2 cycles after accept, sum=8'h00, cout=1, ovf=0; busy low in the done cycle.
- Start held high continuously with changing operands -> second operation accepted in first done cycle, start pulses during busy ignored, results match operands sampled on accept only.
- Reset asserted at slice 3 of an 8-slice operation -> no done pulse, all outputs 0, next start completes normally.
- With SERIAL_ADD_SUB_EN, WIDTH=8: a=8'h10, b=8'h20, sub=1, cin=0 -> sum=8'hF0, cout=0; a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, ovf=1.

Source files
------------

// File: rtl/serial_add.sv
// serial_add: multi-cycle adder that processes SLICE bits per clock, LSB slice
// first, under a start/busy/done handshake. Result outputs update only on done.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' input. With sub=1 the
// block computes a + ~b + (cin^1), which is a - b when cin=0.
module serial_add #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSL = WIDTH / SLICE;
  localparam int unsigned KW  = (NSL > 1) ? $clog2(NSL) : 1;

  // Reject parameter sets where the slices do not tile the operand exactly.
  if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_chk
    $error("serial_add: WIDTH must be a nonzero multiple of SLICE");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_nx;
  logic [KW-1:0]    r_k, w_k_nx;
  logic [WIDTH-1:0] r_a, w_a_nx;
  logic [WIDTH-1:0] r_b, w_b_nx;
  logic [WIDTH-1:0] r_res, w_res_nx;
  logic             r_carry, w_carry_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic [WIDTH-1:0] r_sum, w_sum_nx;
  logic             r_cout, w_cout_nx;
  logic             r_ovf, w_ovf_nx;

  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic [SLICE-1:0] w_s;
  logic [SLICE:0]   w_c;
  logic [WIDTH-1:0] w_res_sh;
  logic             w_last;

  // Operand conditioning applied once, at accept time.
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_in   = sub ? ~b : b;
  assign w_cin_in = cin ^ sub;
`else
  assign w_b_in   = b;
  assign w_cin_in = cin;
`endif

  // Operands are shifted right each RUN cycle, so the active slice is always
  // in the low SLICE bits; the result fills in from the top and is aligned
  // after NSL shifts.
  always_comb begin
    w_s    = '0;
    w_c    = '0;
    w_c[0] = r_carry;
    for (int j = 0; j < int'(SLICE); j++) begin
      w_s[j]   = r_a[j] ^ r_b[j] ^ w_c[j];
      w_c[j+1] = (r_a[j] & r_b[j]) | (r_a[j] & w_c[j]) | (r_b[j] & w_c[j]);
    end
    w_res_sh = (r_res >> SLICE) | (WIDTH'(w_s) << (WIDTH - SLICE));
  end

  assign w_last = (r_k == KW'(NSL - 1));

  // Next-state and datapath update for the IDLE/RUN controller.
  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_res_nx   = r_res;
    w_carry_nx = r_carry;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_sum_nx   = r_sum;
    w_cout_nx  = r_cout;
    w_ovf_nx   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_RUN;
          w_k_nx     = '0;
          w_a_nx     = a;
          w_b_nx     = w_b_in;
          w_carry_nx = w_cin_in;
          w_res_nx   = '0;
          w_busy_nx  = 1'b1;
        end
      end
      S_RUN: begin
        w_a_nx     = r_a >> SLICE;
        w_b_nx     = r_b >> SLICE;
        w_res_nx   = w_res_sh;
        w_carry_nx = w_c[SLICE];
        w_k_nx     = r_k + 1'b1;
        if (w_last) begin
          w_state_nx = S_IDLE;
          w_k_nx     = '0;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_sum_nx   = w_res_sh;
          w_cout_nx  = w_c[SLICE];
          // Carry into the MSB is the carry into the top cell of the last slice.
          w_ovf_nx   = w_c[SLICE] ^ w_c[SLICE-1];
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_res   <= w_res_nx;
      r_carry <= w_carry_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_sum   <= w_sum_nx;
      r_cout  <= w_cout_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
